// File: rtl/score_capture.sv
// Receiver for the scoreboard controller's display buses: snapshots the six
// 7-segment digits on each rising edge of done, decodes them, and scores the result.
module score_capture #(
  parameter logic [9:0] THRESHOLD = 10'd40,
  parameter logic [9:0] HS_INIT   = 10'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       done,
  input  logic [6:0] seg7_points_2,
  input  logic [6:0] seg7_points_1,
  input  logic [6:0] seg7_points_0,
  input  logic [6:0] seg7_timer_1,
  input  logic [6:0] seg7_timer_0,
  input  logic [6:0] seg7_level,
  input  logic       clr_high,
  output logic       busy,
  output logic       valid,
  output logic [9:0] score_bin,
  output logic [3:0] level_bcd,
  output logic [7:0] time_bcd,
  output logic       pass,
  output logic       new_high,
  output logic [9:0] high_score,
  output logic       decode_err
);

  typedef enum logic [2:0] {IDLE, DECODE, CONV, CMP, REPORT} state_t;

  state_t     state;
  logic       done_q;
  logic       armed;
  logic       err;
  logic [2:0] cnt;
  logic [6:0] snap [0:5];
  logic [3:0] dig  [0:5];
  logic [9:0] acc;
  logic [4:0] dec;
  logic [3:0] conv_dig;
  logic       rise;

  // Returns {illegal, digit}; illegal codes decode to digit 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0111111: seg_decode = {1'b0, 4'd0};
      7'b0000110: seg_decode = {1'b0, 4'd1};
      7'b1011011: seg_decode = {1'b0, 4'd2};
      7'b1001111: seg_decode = {1'b0, 4'd3};
      7'b1100110: seg_decode = {1'b0, 4'd4};
      7'b1101101: seg_decode = {1'b0, 4'd5};
      7'b1111100: seg_decode = {1'b0, 4'd6};
      7'b0000111: seg_decode = {1'b0, 4'd7};
      7'b1111111: seg_decode = {1'b0, 4'd8};
      7'b1100111: seg_decode = {1'b0, 4'd9};
      default:    seg_decode = {1'b1, 4'd0};
    endcase
  endfunction

  // armed blocks the first cycle after reset so a done already held high is not seen as a rise
  assign rise     = done & ~done_q & armed;
  assign dec      = seg_decode(snap[cnt]);
  assign conv_dig = (cnt == 3'd0) ? dig[0] : (cnt == 3'd1) ? dig[1] : dig[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      done_q     <= 1'b0;
      armed      <= 1'b0;
      err        <= 1'b0;
      cnt        <= 3'd0;
      acc        <= 10'd0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      score_bin  <= 10'd0;
      level_bcd  <= 4'd0;
      time_bcd   <= 8'd0;
      pass       <= 1'b0;
      new_high   <= 1'b0;
      high_score <= HS_INIT;
      decode_err <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        snap[i] <= 7'd0;
        dig[i]  <= 4'd0;
      end
    end else begin
      done_q <= done;
      armed  <= 1'b1;
      valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            snap[0] <= seg7_points_2;
            snap[1] <= seg7_points_1;
            snap[2] <= seg7_points_0;
            snap[3] <= seg7_timer_1;
            snap[4] <= seg7_timer_0;
            snap[5] <= seg7_level;
            err     <= 1'b0;
            cnt     <= 3'd0;
            busy    <= 1'b1;
            state   <= DECODE;
          end
        end
        DECODE: begin
          dig[cnt] <= dec[3:0];
          if (dec[4]) err <= 1'b1;
          if (cnt == 3'd5) begin
            cnt   <= 3'd0;
            state <= CONV;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CONV: begin
          if (cnt == 3'd0) acc <= {6'd0, conv_dig};
          else             acc <= acc * 10'd10 + {6'd0, conv_dig};
          if (cnt == 3'd2) begin
            cnt   <= 3'd0;
            state <= CMP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CMP: begin
          if (err) begin
            score_bin <= 10'd0;
            pass      <= 1'b0;
            new_high  <= 1'b0;
          end else begin
            score_bin <= acc;
            pass      <= (acc >= THRESHOLD);
            new_high  <= (acc > high_score);
            if (acc > high_score) high_score <= acc;
          end
          level_bcd  <= dig[5];
          time_bcd   <= {dig[3], dig[4]};
          decode_err <= err;
          valid      <= 1'b1;
          state      <= REPORT;
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Placed last so a clear overrides a same-cycle high-score update
      if (clr_high) high_score <= HS_INIT;
    end
  end

endmodule
